// File: rtl/seg_pkg.sv
// Shared 7-segment definitions: active-low patterns (gfedcba, 0 = lit),
// event kinds and the pattern-to-nibble reverse map.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    EV_HEX     = 2'd0,
    EV_BLANK   = 2'd1,
    EV_ILLEGAL = 2'd2
  } ev_kind_e;

  typedef struct packed {
    ev_kind_e   kind;
    logic [3:0] value;
  } seg_dec_t;

  // Value is forced to 0 for blank and illegal patterns.
  function automatic seg_dec_t seg_to_nibble(input logic [6:0] pat);
    seg_dec_t r;
    r.kind  = EV_HEX;
    r.value = 4'h0;
    case (pat)
      SEG_0:     r.value = 4'h0;
      SEG_1:     r.value = 4'h1;
      SEG_2:     r.value = 4'h2;
      SEG_3:     r.value = 4'h3;
      SEG_4:     r.value = 4'h4;
      SEG_5:     r.value = 4'h5;
      SEG_6:     r.value = 4'h6;
      SEG_7:     r.value = 4'h7;
      SEG_8:     r.value = 4'h8;
      SEG_9:     r.value = 4'h9;
      SEG_A:     r.value = 4'hA;
      SEG_B:     r.value = 4'hB;
      SEG_C:     r.value = 4'hC;
      SEG_D:     r.value = 4'hD;
      SEG_E:     r.value = 4'hE;
      SEG_F:     r.value = 4'hF;
      SEG_BLANK: r.kind  = EV_BLANK;
      default:   r.kind  = EV_ILLEGAL;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg_sync.sv
// Two-flop synchronizer; resets to all ones (idle level of active-low lines).
module seg_sync #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Metastability chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/seg_reader.sv
// Recovers hex digits from a multiplexed active-low 7-segment bus and reports
// each stored digit change on a single-entry valid/ready event port.
module seg_reader
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 16,
  localparam int unsigned CNT_W        = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
  output logic [4*DIGITS-1:0]   digits,
  output logic [DIGITS-1:0]     digit_vld,
  output logic                  ev_valid,
  input  logic                  ev_ready,
  output logic [2:0]            ev_digit,
  output logic [3:0]            ev_value,
  output logic [1:0]            ev_kind,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]        s_seg;
  logic [DIGITS-1:0] s_an;

  seg_sync #(.WIDTH(7)) u_sync_seg (
    .clk (clk),
    .rst (rst),
    .d   (seg_n),
    .q   (s_seg)
  );

  seg_sync #(.WIDTH(DIGITS)) u_sync_an (
    .clk (clk),
    .rst (rst),
    .d   (an_n),
    .q   (s_an)
  );

  // Stability tracking state.
  logic [6+DIGITS:0] sample_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              committed_q, committed_d;
  logic              stable, one_zero, commit;
  logic [3:0]        zeros;

  // Per-digit stored state; kind is kept internally so illegal is remembered.
  logic [4*DIGITS-1:0] digits_q;
  logic [DIGITS-1:0]   vld_q;
  ev_kind_e            kind_q [DIGITS];

  // Event register.
  logic       ev_valid_q;
  logic [2:0] ev_digit_q;
  logic [3:0] ev_value_q;
  ev_kind_e   ev_kind_q;
  logic       ovf_q;

  seg_dec_t          dec;
  logic              new_vld, changed, ev_new, ev_load, ev_drop;
  logic [2:0]        sel_idx;
  logic [DIGITS-1:0] wr_en;

  // Stability counter and commit decision.
  always_comb begin
    stable = ({s_seg, s_an} == sample_q);
    zeros  = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      zeros = zeros + {3'b000, ~s_an[i]};
    end
    one_zero = (zeros == 4'd1);
    // Requiring equality this cycle too keeps a just-changed pattern out.
    commit   = stable && (cnt_q == CntMax) && !committed_q && one_zero;

    cnt_d       = cnt_q;
    committed_d = committed_q;
    if (!stable) begin
      cnt_d       = '0;
      committed_d = 1'b0;
    end else begin
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      if (commit) begin
        committed_d = 1'b1;
      end
    end
  end

  // Decode the stable pattern and compare it with the selected digit's state.
  always_comb begin
    dec     = seg_to_nibble(s_seg);
    new_vld = (dec.kind == EV_HEX);
    sel_idx = 3'd0;
    changed = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!s_an[i]) begin
        sel_idx = 3'(i);
        if ((new_vld != vld_q[i]) || (dec.value != digits_q[4*i +: 4]) ||
            (dec.kind != kind_q[i])) begin
          changed = 1'b1;
        end
      end
    end
    ev_new  = commit && changed;
    wr_en   = ev_new ? ~s_an : '0;
    ev_load = ev_new && (!ev_valid_q || ev_ready);
    ev_drop = ev_new && ev_valid_q && !ev_ready;
  end

  // Sample register, counter and commit flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q    <= '1;
      cnt_q       <= '0;
      committed_q <= 1'b0;
    end else begin
      sample_q    <= {s_seg, s_an};
      cnt_q       <= cnt_d;
      committed_q <= committed_d;
    end
  end

  // Digit storage; updates even when the event itself is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits_q <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        kind_q[i] <= EV_BLANK;
      end
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en[i]) begin
          digits_q[4*i +: 4] <= dec.value;
          vld_q[i]           <= new_vld;
          kind_q[i]          <= dec.kind;
        end
      end
    end
  end

  // Single-entry event register with back-to-back load and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_valid_q <= 1'b0;
      ev_digit_q <= 3'd0;
      ev_value_q <= 4'd0;
      ev_kind_q  <= EV_HEX;
      ovf_q      <= 1'b0;
    end else begin
      if (ev_load) begin
        ev_valid_q <= 1'b1;
        ev_digit_q <= sel_idx;
        ev_value_q <= dec.value;
        ev_kind_q  <= dec.kind;
      end else if (ev_valid_q && ev_ready) begin
        ev_valid_q <= 1'b0;
      end
      if (ev_drop) begin
        ovf_q <= 1'b1;
      end else if (clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

  assign digits    = digits_q;
  assign digit_vld = vld_q;
  assign ev_valid  = ev_valid_q;
  assign ev_digit  = ev_digit_q;
  assign ev_value  = ev_value_q;
  assign ev_kind   = ev_kind_q;
  assign ovf       = ovf_q;

endmodule

// File: doc/seg_reader.md
Name: seg_reader

Overview:
- Recovers hex digits from a multiplexed, active-low 7-segment bus, the inverse of the team's hex-to-segment decoder.
- Samples the segment lines (a=bit0 … g=bit6, 0 = lit) and active-low digit selects, and requires a stable pattern per digit.
- Maps each stable pattern back to a 4-bit nibble and stores it per digit.
- Reports every digit change on a valid/ready event port for the test/loopback logic behind the display driver.

Parameters:
- DIGITS, 4, number of multiplexed digits (1..8).
- STABLE_CYCLES, 16, consecutive identical synchronized samples required before a commit (>=2).
- CNT_W, $clog2(STABLE_CYCLES+1), stability counter width; derived, not overridden.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- seg_n  in  7  segment lines, active-low, bit0=a … bit6=g, asynchronous to clk.
- an_n  in  DIGITS  digit selects, active-low, asynchronous to clk.
- digits  out  4*DIGITS  stored nibble per digit, digit i at [4i+3:4i].
- digit_vld  out  DIGITS  1 = digit i holds a decoded hex value; 0 = blank or never seen.
- ev_valid  out  1  change event pending.
- ev_ready  in  1  consumer accepts the event when ev_valid&&ev_ready.
- ev_digit  out  3  index of the changed digit.
- ev_value  out  4  new nibble (0 when blank or error).
- ev_kind  out  2  0=hex, 1=blank, 2=illegal pattern.
- ovf  out  1  sticky: an event was dropped.
- clr_ovf  in  1  synchronous clear of ovf.

Behaviour:
- Reset (async, rst=1): all sync flops to 1 (idle/off), counter 0, digits=0, digit_vld=0, ev_valid=0, ev_digit=0, ev_value=0, ev_kind=0, ovf=0, committed flag=0.
- Synchronization: seg_n and an_n each pass a 2-flop synchronizer. All further logic uses the synchronized values (s_seg, s_an).
- Stability:
  - Sample register holds the previous {s_seg, s_an}.
  - Any difference: counter=0, committed=0.
  - Otherwise the counter increments and saturates at STABLE_CYCLES-1.
- Commit condition: counter==STABLE_CYCLES-1 && committed==0 && s_an has exactly one zero. Commit sets committed=1, so at most one commit per stable window.
  - s_an all ones (inter-digit blanking) or more than one zero: no commit, nothing else changes.
- Reverse map (active-low pattern gfedcba → nibble):
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7.
  - 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
  - 0x7F→blank (kind 1).
  - Any other pattern→illegal (kind 2).
- On commit for digit i, with new state {vld, value, kind} (value 0 unless kind 0):
  - If it equals the stored state, no event is generated.
  - Otherwise digits[i] and digit_vld[i] update on the next edge. Stored kind is kept internally and includes illegal.
  - An event is generated.
- Event register (one entry):
  - Loads when ev_valid==0, or when ev_valid&&ev_ready in the same cycle (back-to-back allowed, no bubble).
  - Otherwise the event is dropped and ovf←1. The digit storage still updates.
  - ev_valid clears on handshake with no new event.
  - Outputs are held stable while ev_valid&&!ev_ready.
- ovf: set has priority over a simultaneous clr_ovf.
- Latency: a clean input change reaches ev_valid=1 after 2 (sync) + STABLE_CYCLES + 1 clocks.
- Glitches shorter than STABLE_CYCLES synchronized cycles never commit.
- Reset mid-operation clears immediately, including any pending event. After release, the first stable digit commits (stored state starts as not-valid/kind blank, so a real hex digit always produces an event).

Decomposition:
- Shared package seg_pkg:
  - Active-low pattern constants SEG_0..SEG_F and SEG_BLANK.
  - Event kind enum (EV_HEX, EV_BLANK, EV_ILLEGAL).
  - Function seg_to_nibble returning {kind, value}. The same constants serve the forward decoder's tests.
- One sub-module: seg_sync, a 2-flop synchronizer parameterized by width and instantiated for seg_n and an_n.

Test Plan:
- Reset, then hold an_n=4'b1110, seg_n=0x30 → after 2+16+1 clocks ev_valid=1, ev_digit=0, ev_value=3, ev_kind=0; digits[3:0]=3, digit_vld[0]=1.
- Scan 4 digits at 40 clocks each with patterns 0x12, 0x00, 0x08, 0x21, ev_ready=1 → four events with values 5, 8, A, d. Rescanning the same patterns → no further events.
- On digit 1, apply 0x79 with 5-cycle pulses of 0x00 interleaved → only value 1 committed; no event for 8.
- Hold ev_ready=0, then change digits 0 and 2 → first event held unchanged; second dropped; ovf=1; digits reflects both changes. clr_ovf pulse → ovf=0.
- Digit 3 pattern 0x55 → event kind 2, value 0, digit_vld[3]=0. Then 0x7F → event kind 1. Then an_n=4'b1100 (two active) for 100 cycles → no events.
- Assert rst for 1 cycle while an event is pending → ev_valid=0, digits=0, digit_vld=0 asynchronously. The stable pattern recommits after 2+16+1 clocks.
